audio_i2s_master: RTL and testbench
===================================

// Module: audio_i2s_master
// PURPOSE
//  Clock-master end of the codec serial audio link: derives AUD_BCK and AUD_LRCK from iCLK.
//  Serializes a stereo DAC sample pair onto AUD_DACDAT and deserializes AUD_ADCDAT into a stereo pair.
//  Frame format: DATA_W bits/channel, MSB first, no 1-bit delay; LRCK=1 left slot, LRCK=0 right slot.
//  Sits between the sample-processing logic (valid/ready on the DAC side, strobe on the ADC side) and the codec pins.
// PARAMETERS
//  DATA_W   16  bits per channel; frame = 2*DATA_W BCK periods
//  CLK_DIV  6   iCLK cycles per BCK half-period (>=2); 18.432 MHz/12/32 = 48 kHz
// PORTS
//  iCLK           in   1       system clock; all logic on posedge
//  iRST_N         in   1       asynchronous active-low reset
//  iDAC_L         in   DATA_W  left sample to play
//  iDAC_R         in   DATA_W  right sample to play
//  iDAC_VALID     in   1       iDAC_L/R valid
//  oDAC_READY     out  1       holding register empty; accept when VALID&&READY
//  oDAC_UNDERRUN  out  1       1-cycle pulse: frame started with holding register empty
//  oADC_L         out  DATA_W  last complete captured left sample
//  oADC_R         out  DATA_W  last complete captured right sample
//  oADC_VALID     out  1       1-cycle pulse: oADC_L/R updated
//  AUD_BCK        out  1       bit clock to codec (registered)
//  AUD_LRCK       out  1       left/right clock to codec (registered)
//  AUD_DACDAT     out  1       serial DAC data (registered)
//  AUD_ADCDAT     in   1       serial ADC data from codec
// BEHAVIOUR
//  Reset: AUD_BCK=0, AUD_LRCK=0, AUD_DACDAT=0, oDAC_READY=1, oDAC_UNDERRUN=0, oADC_L/R=0,
//   oADC_VALID=0; div cnt=0, slot=2*DATA_W-1, holding reg empty, DAC shift/last words=0.
//  Divider: div counts 0..CLK_DIV-1; tick when div==CLK_DIV-1; on tick AUD_BCK toggles.
//   BCK period = 2*CLK_DIV; frame = 4*DATA_W*CLK_DIV iCLK cycles (384 at defaults).
//  Falling tick (BCK 1->0): slot <= (slot+1) mod 2*DATA_W; AUD_LRCK <= (new slot < DATA_W);
//   AUD_DACDAT <= left word bit [DATA_W-1-slot] in left slots, right word bit [2*DATA_W-1-slot] in right slots.
//  Rising tick (BCK 0->1): AUD_ADCDAT sampled into capture bit for current slot (same bit mapping).
//  Frame start = falling tick into slot 0. If holding full: load holding into DAC words, clear holding.
//   If empty: replay previous DAC words (zeros after reset); oDAC_UNDERRUN=1 next cycle.
//  Holding register: oDAC_READY = !full. VALID&&READY captures iDAC_L/R and sets full.
//   Accept in the same cycle as frame start with holding empty: counts as underrun; sample is kept for the next frame.
//   Latency: accepted sample begins on AUD_DACDAT at the next frame start.
//  ADC: on the rising tick of slot 2*DATA_W-1, the capture regs (with that bit) go to oADC_L/R; oADC_VALID=1 for one cycle.
//   Suppressed until one full frame (slot 0 through 2*DATA_W-1) has been captured after reset. Exactly one pulse per frame.
//  First BCK rise after reset is at iCLK cycle CLK_DIV; first frame start is at cycle 2*CLK_DIV, with LRCK->1.
//  Reset asserted mid-frame: all state returns to reset values immediately; the partial frame is discarded, no VALID pulse.
//  Pin outputs are glitch-free: they are driven only from flops.
// TESTING
//  1 Reset then run 1000 cycles, defaults -> BCK period 12, LRCK period 384 high 192, LRCK rises with BCK fall.
//  2 DACDAT looped to ADCDAT, write L=16'hA5C3 R=16'h1234 -> next complete frame gives oADC_L=A5C3 R=1234, VALID once/384.
//  3 L=16'h8000 R=16'h0001 -> DACDAT high only in first BCK of LRCK=1 and last BCK of LRCK=0.
//  4 One sample then no VALID for 3 frames -> sample replayed 3 times, oDAC_UNDERRUN pulses at each of those frame starts.
//  5 VALID held high with incrementing data -> READY low between frame starts, exactly one accept per frame, none lost/duplicated.
//  6 Assert iRST_N low mid right slot for 3 cycles -> outputs at reset values, no oADC_VALID until a full new frame completes.

Source files
------------

// File: rtl/audio_i2s_master.sv
// Clock-master end of the codec serial audio link: generates AUD_BCK/AUD_LRCK,
// serializes a stereo DAC pair onto AUD_DACDAT and deserializes AUD_ADCDAT.
module audio_i2s_master #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 6
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [DATA_W-1:0] iDAC_L,
    input  logic [DATA_W-1:0] iDAC_R,
    input  logic              iDAC_VALID,
    output logic              oDAC_READY,
    output logic              oDAC_UNDERRUN,
    output logic [DATA_W-1:0] oADC_L,
    output logic [DATA_W-1:0] oADC_R,
    output logic              oADC_VALID,
    output logic              AUD_BCK,
    output logic              AUD_LRCK,
    output logic              AUD_DACDAT,
    input  logic              AUD_ADCDAT
);

    localparam int FRAME_BITS = 2 * DATA_W;
    localparam int SLOT_W     = $clog2(FRAME_BITS);
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_BITS - 1);
    localparam logic [SLOT_W-1:0] LEFT_END  = SLOT_W'(DATA_W);
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]      div;
    logic [SLOT_W-1:0]     slot;
    logic [SLOT_W-1:0]     slot_next;
    logic                  tick;
    logic                  rise_tick;
    logic                  fall_tick;
    logic                  frame_start;
    logic                  dac_accept;
    logic                  hold_full;
    logic [DATA_W-1:0]     hold_l;
    logic [DATA_W-1:0]     hold_r;
    logic [DATA_W-1:0]     dac_l;
    logic [DATA_W-1:0]     dac_r;
    logic [FRAME_BITS-1:0] frame_word;
    logic [FRAME_BITS-1:0] cap;
    logic [FRAME_BITS-1:0] cap_done;
    logic                  armed;

    assign tick        = (div == DIV_MAX);
    assign rise_tick   = tick && !AUD_BCK;
    assign fall_tick   = tick && AUD_BCK;
    assign slot_next   = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
    assign frame_start = fall_tick && (slot_next == '0);
    assign dac_accept  = iDAC_VALID && !hold_full;
    assign oDAC_READY  = !hold_full;

    // Left word occupies the upper half so one index (LAST_SLOT - slot) serves both channels.
    always_comb begin
        frame_word = {dac_l, dac_r};
        if (frame_start && hold_full)
            frame_word = {hold_l, hold_r};
    end

    always_comb begin
        cap_done    = cap;
        cap_done[0] = AUD_ADCDAT;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            div     <= '0;
            AUD_BCK <= 1'b0;
        end else if (tick) begin
            div     <= '0;
            AUD_BCK <= !AUD_BCK;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Slot advance, LRCK and DAC bit all change together on the BCK falling tick.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            slot       <= LAST_SLOT;
            AUD_LRCK   <= 1'b0;
            AUD_DACDAT <= 1'b0;
            dac_l      <= '0;
            dac_r      <= '0;
        end else if (fall_tick) begin
            slot       <= slot_next;
            AUD_LRCK   <= (slot_next < LEFT_END);
            AUD_DACDAT <= frame_word[LAST_SLOT - slot_next];
            if (frame_start) begin
                dac_l <= frame_word[FRAME_BITS-1:DATA_W];
                dac_r <= frame_word[DATA_W-1:0];
            end
        end
    end

    // An accept coinciding with an empty-register frame start is kept for the following frame.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hold_full     <= 1'b0;
            hold_l        <= '0;
            hold_r        <= '0;
            oDAC_UNDERRUN <= 1'b0;
        end else begin
            oDAC_UNDERRUN <= frame_start && !hold_full;
            if (frame_start && hold_full) begin
                hold_full <= 1'b0;
            end else if (dac_accept) begin
                hold_full <= 1'b1;
                hold_l    <= iDAC_L;
                hold_r    <= iDAC_R;
            end
        end
    end

    // armed blocks the partial frame seen right after reset from producing a VALID pulse.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cap        <= '0;
            armed      <= 1'b0;
            oADC_L     <= '0;
            oADC_R     <= '0;
            oADC_VALID <= 1'b0;
        end else begin
            oADC_VALID <= 1'b0;
            if (rise_tick) begin
                cap[LAST_SLOT - slot] <= AUD_ADCDAT;
                if (slot == '0)
                    armed <= 1'b1;
                if (slot == LAST_SLOT && armed) begin
                    oADC_L     <= cap_done[FRAME_BITS-1:DATA_W];
                    oADC_R     <= cap_done[DATA_W-1:0];
                    oADC_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_master.sv
// Bench for audio_i2s_master: DACDAT looped to ADCDAT, a cycle-count based
// frame model checked every cycle, plus directed scenarios with literal expectations.
module tb_audio_i2s_master;

    localparam int DW = 16;
    localparam int CD = 6;
    localparam int FB = 2 * DW;

    logic          iCLK = 1'b0;
    logic          rst_n;
    logic [DW-1:0] dac_l;
    logic [DW-1:0] dac_r;
    logic          dac_valid;
    logic          dac_ready;
    logic          dac_underrun;
    logic [DW-1:0] adc_l;
    logic [DW-1:0] adc_r;
    logic          adc_valid;
    logic          aud_bck;
    logic          aud_lrck;
    logic          aud_dacdat;
    logic          aud_adcdat;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;

    // Model state: k = clock edges since reset release, everything else derives from it.
    int            k;
    logic          m_full;
    logic [DW-1:0] m_hold_l, m_hold_r, m_word_l, m_word_r, m_cap_l, m_cap_r;
    bit            m_seen;
    logic          e_bck, e_lrck, e_dacdat, e_ready, e_underrun, e_adc_valid;
    logic [DW-1:0] e_adc_l, e_adc_r;

    assign aud_adcdat = aud_dacdat;

    always #5 iCLK = ~iCLK;

    audio_i2s_master #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .iCLK          (iCLK),
        .iRST_N        (rst_n),
        .iDAC_L        (dac_l),
        .iDAC_R        (dac_r),
        .iDAC_VALID    (dac_valid),
        .oDAC_READY    (dac_ready),
        .oDAC_UNDERRUN (dac_underrun),
        .oADC_L        (adc_l),
        .oADC_R        (adc_r),
        .oADC_VALID    (adc_valid),
        .AUD_BCK       (aud_bck),
        .AUD_LRCK      (aud_lrck),
        .AUD_DACDAT    (aud_dacdat),
        .AUD_ADCDAT    (aud_adcdat)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        k = 0;
        m_full = 0; m_seen = 0;
        m_hold_l = '0; m_hold_r = '0; m_word_l = '0; m_word_r = '0;
        m_cap_l = '0; m_cap_r = '0;
        e_bck = 0; e_lrck = 0; e_dacdat = 0; e_ready = 1; e_underrun = 0; e_adc_valid = 0;
        e_adc_l = '0; e_adc_r = '0;
    endtask

    // Half-period h ends at edge k = h*CD; even h are BCK falls, odd h are BCK rises.
    task automatic modelStep();
        int   h, f, s;
        logic acc;
        k++;
        e_underrun  = 0;
        e_adc_valid = 0;
        acc = dac_valid && !m_full;
        if (k % CD == 0) begin
            h = k / CD;
            e_bck = (h % 2 == 1);
            if (h % 2 == 0) begin
                f = h / 2;
                s = (f - 1) % FB;
                e_lrck = (s < DW);
                if (s == 0) begin
                    if (m_full) begin
                        m_word_l = m_hold_l;
                        m_word_r = m_hold_r;
                        m_full = 0;
                    end else begin
                        e_underrun = 1;
                    end
                end
                e_dacdat = (s < DW) ? m_word_l[DW-1-s] : m_word_r[FB-1-s];
            end else begin
                f = (h - 1) / 2;
                s = (f + FB - 1) % FB;
                if (s < DW) m_cap_l[DW-1-s] = e_dacdat;
                else        m_cap_r[FB-1-s] = e_dacdat;
                if (s == 0) m_seen = 1;
                if (s == FB - 1 && m_seen) begin
                    e_adc_l = m_cap_l;
                    e_adc_r = m_cap_r;
                    e_adc_valid = 1;
                end
            end
        end
        if (acc) begin
            m_full = 1;
            m_hold_l = dac_l;
            m_hold_r = dac_r;
        end
        e_ready = !m_full;
    endtask

    initial forever begin
        @(posedge iCLK or negedge rst_n);
        if (!rst_n) modelReset();
        else        modelStep();
    end

    initial forever begin
        @(negedge iCLK);
        if (chk_en) begin
            checkOutput("bck",       32'(aud_bck),      32'(e_bck));
            checkOutput("lrck",      32'(aud_lrck),     32'(e_lrck));
            checkOutput("dacdat",    32'(aud_dacdat),   32'(e_dacdat));
            checkOutput("ready",     32'(dac_ready),    32'(e_ready));
            checkOutput("underrun",  32'(dac_underrun), 32'(e_underrun));
            checkOutput("adc_valid", 32'(adc_valid),    32'(e_adc_valid));
            checkOutput("adc_l",     32'(adc_l),        32'(e_adc_l));
            checkOutput("adc_r",     32'(adc_r),        32'(e_adc_r));
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bit   done = 0;
        logic rdy;
        dac_l = l;
        dac_r = r;
        dac_valid = 1;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(negedge iCLK);
            rdy = dac_ready;
            @(posedge iCLK);
            #1;
            if (rdy) done = 1;
        end
        dac_valid = 0;
        checkOutput("accept_done", 32'(done), 32'd1);
    endtask

    task automatic waitLrckEdge(input logic lvl);
        bit   ok = 0;
        logic prev;
        @(negedge iCLK);
        prev = aud_lrck;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge iCLK);
            if (aud_lrck == lvl && prev != lvl) ok = 1;
            prev = aud_lrck;
        end
        checkOutput("lrck_edge_found", 32'(ok), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_bck"},       32'(aud_bck),      32'd0);
        checkOutput({tag, "_lrck"},      32'(aud_lrck),     32'd0);
        checkOutput({tag, "_dacdat"},    32'(aud_dacdat),   32'd0);
        checkOutput({tag, "_ready"},     32'(dac_ready),    32'd1);
        checkOutput({tag, "_underrun"},  32'(dac_underrun), 32'd0);
        checkOutput({tag, "_adc_valid"}, 32'(adc_valid),    32'd0);
        checkOutput({tag, "_adc_l"},     32'(adc_l),        32'd0);
        checkOutput({tag, "_adc_r"},     32'(adc_r),        32'd0);
    endtask

    initial begin
        bit   s_bck [0:1000];
        bit   s_lrck[0:1000];
        bit   s_dat [0:383];
        int   first_bck, second_bck, first_lrck, second_lrck, lrck_high;
        int   cnt_a, cnt_b, cnt_c, n;
        bit   found, got;
        logic rdy;
        logic [DW-1:0] dl, dr, prev_l;

        rst_n = 0;
        dac_valid = 0;
        dac_l = '0;
        dac_r = '0;
        modelReset();
        #2 chk_en = 1;

        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        checkResetValues("init");
        @(posedge iCLK);
        #1 rst_n = 1;

        $display("[TB] test 1: free-running clocks");
        for (int i = 0; i <= 1000; i++) begin
            @(negedge iCLK);
            s_bck[i]  = aud_bck;
            s_lrck[i] = aud_lrck;
        end
        first_bck = -1; second_bck = -1; first_lrck = -1; second_lrck = -1; lrck_high = 0;
        for (int i = 1; i <= 1000; i++) begin
            if (s_bck[i] && !s_bck[i-1]) begin
                if (first_bck < 0) first_bck = i;
                else if (second_bck < 0) second_bck = i;
            end
            if (s_lrck[i] && !s_lrck[i-1]) begin
                if (first_lrck < 0) first_lrck = i;
                else if (second_lrck < 0) second_lrck = i;
            end
        end
        for (int i = 12; i < 396; i++) lrck_high += int'(s_lrck[i]);
        checkOutput("t1_first_bck_rise",  32'(first_bck),  32'd6);
        checkOutput("t1_bck_period",      32'(second_bck - first_bck), 32'd12);
        checkOutput("t1_first_lrck_rise", 32'(first_lrck), 32'd12);
        checkOutput("t1_lrck_period",     32'(second_lrck - first_lrck), 32'd384);
        checkOutput("t1_lrck_high",       32'(lrck_high),  32'd192);
        checkOutput("t1_lrck_with_bck_fall", 32'({s_bck[395], s_bck[396]}), 32'b10);

        $display("[TB] test 2: loopback A5C3/1234");
        applyStimulus(16'hA5C3, 16'h1234);
        found = 0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge iCLK);
            if (adc_valid && adc_l == 16'hA5C3) found = 1;
        end
        checkOutput("t2_found", 32'(found), 32'd1);
        checkOutput("t2_adc_l", 32'(adc_l), 32'hA5C3);
        checkOutput("t2_adc_r", 32'(adc_r), 32'h1234);
        n = 0; got = 0;
        while (!got && n < 500) begin
            @(negedge iCLK);
            n++;
            if (adc_valid) got = 1;
        end
        checkOutput("t2_valid_spacing", 32'(n), 32'd384);
        checkOutput("t2_replay_l", 32'(adc_l), 32'hA5C3);

        $display("[TB] test 3: MSB/LSB placement 8000/0001");
        applyStimulus(16'h8000, 16'h0001);
        waitLrckEdge(1'b1);
        s_dat[0] = aud_dacdat;
        for (int i = 1; i < 384; i++) begin
            @(negedge iCLK);
            s_dat[i] = aud_dacdat;
        end
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 384; i++) begin
            cnt_c += int'(s_dat[i]);
            if (i < 12)   cnt_a += int'(s_dat[i]);
            if (i >= 372) cnt_b += int'(s_dat[i]);
        end
        checkOutput("t3_left_msb_bck",  32'(cnt_a), 32'd12);
        checkOutput("t3_right_lsb_bck", 32'(cnt_b), 32'd12);
        checkOutput("t3_total_high",    32'(cnt_c), 32'd24);

        $display("[TB] test 4: underrun replay");
        applyStimulus(16'h0F0F, 16'hF0F0);
        waitLrckEdge(1'b1);
        cnt_a = 0; cnt_b = 0;
        for (int i = 1; i < 1536; i++) begin
            @(negedge iCLK);
            if (dac_underrun) cnt_a++;
            if (adc_valid && adc_l == 16'h0F0F && adc_r == 16'hF0F0) cnt_b++;
        end
        checkOutput("t4_underruns", 32'(cnt_a), 32'd3);
        checkOutput("t4_replays",   32'(cnt_b), 32'd4);

        $display("[TB] test 5: streaming with VALID held high");
        dl = 16'h1000; dr = 16'h2000;
        dac_l = dl; dac_r = dr; dac_valid = 1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0; prev_l = '0;
        for (int c = 0; c < 2304; c++) begin
            @(negedge iCLK);
            rdy = dac_ready;
            if (c >= 768 && adc_valid) begin
                if (cnt_a > 0 && adc_l == 16'(prev_l + 16'd1)) cnt_b++;
                if (adc_r == 16'(adc_l + 16'h1000)) cnt_c++;
                prev_l = adc_l;
                cnt_a++;
            end
            @(posedge iCLK);
            #1;
            if (rdy) begin
                dl = dl + 16'd1;
                dr = dr + 16'd1;
                dac_l = dl;
                dac_r = dr;
            end
        end
        dac_valid = 0;
        checkOutput("t5_frames_received", 32'(cnt_a), 32'd4);
        checkOutput("t5_consecutive",     32'(cnt_b), 32'd3);
        checkOutput("t5_pair_intact",     32'(cnt_c), 32'd4);

        $display("[TB] test 6: reset mid right slot");
        waitLrckEdge(1'b0);
        repeat (50) @(negedge iCLK);
        @(posedge iCLK);
        #1 rst_n = 0;
        @(negedge iCLK);
        checkResetValues("t6");
        repeat (3) @(posedge iCLK);
        #1 rst_n = 1;
        cnt_a = 0; found = 0;
        for (int i = 0; i <= 390; i++) begin
            @(negedge iCLK);
            if (adc_valid) begin
                if (i < 390) cnt_a++;
                else found = 1;
            end
        end
        checkOutput("t6_no_early_valid",  32'(cnt_a), 32'd0);
        checkOutput("t6_first_valid_390", 32'(found), 32'd1);
        checkOutput("t6_first_adc_l",     32'(adc_l), 32'd0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
